// File: rtl/lif_spike_encoder.sv
// Threshold/fire/refractory controller for a LIF neuron with a timestamped event FIFO.
// Optional adaptive threshold enabled by defining LIF_SPIKE_ADAPTIVE_THRESH_EN.
module lif_spike_encoder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TS_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned THRESH_DEFAULT = 128,
  parameter int unsigned REFRAC_DEFAULT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    state,
  input  logic                cfg_we,
  input  logic [WIDTH-1:0]    cfg_threshold,
  input  logic [3:0]          cfg_refrac,
  output logic                spike,
  output logic                refractory,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [TS_WIDTH-1:0] ev_ts,
  output logic                overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_INTEG  = 2'd0,
    ST_FIRE   = 2'd1,
    ST_REFRAC = 2'd2
  } fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]    threshold_q, threshold_d;
  logic [3:0]          refrac_len_q, refrac_len_d;
  logic [TS_WIDTH-1:0] ts_q;
  logic                spike_q, spike_d;
  logic                refrac_q, refrac_d;
  logic [WIDTH-1:0]    thr_eff_c;
  logic                cross_c;

  logic [TS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ev_valid_q, ev_valid_d;
  logic [TS_WIDTH-1:0] ev_ts_q, ev_ts_d;
  logic                ovf_q, ovf_d;
  logic                push_req_c, push_ok_c, pop_c, full_c;

  assign cross_c = (state >= thr_eff_c);

  assign threshold_d  = cfg_we ? cfg_threshold : threshold_q;
  assign refrac_len_d = cfg_we ? cfg_refrac    : refrac_len_q;

`ifdef LIF_SPIKE_ADAPTIVE_THRESH_EN
  localparam logic [WIDTH-1:0] THR_MAX = '1;
  logic [WIDTH-1:0] thr_eff_q, thr_eff_d;

  // Raise by 8 on each fire (saturating), leak back toward the base when quiet.
  always_comb begin
    thr_eff_d = thr_eff_q;
    if (cfg_we) begin
      thr_eff_d = cfg_threshold;
    end else if (fsm_q == ST_FIRE) begin
      if (thr_eff_q > (THR_MAX - WIDTH'(8))) thr_eff_d = THR_MAX;
      else                                   thr_eff_d = thr_eff_q + WIDTH'(8);
    end else if ((fsm_q == ST_INTEG) && !cross_c && (thr_eff_q > threshold_q)) begin
      thr_eff_d = thr_eff_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) thr_eff_q <= WIDTH'(THRESH_DEFAULT);
    else          thr_eff_q <= thr_eff_d;
  end

  assign thr_eff_c = thr_eff_q;
`else
  assign thr_eff_c = threshold_q;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q <= ST_INTEG;
      cnt_q <= 4'd0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      ST_INTEG: begin
        if (cross_c) fsm_d = ST_FIRE;
      end
      ST_FIRE: begin
        if (refrac_len_q != 4'd0) begin
          fsm_d = ST_REFRAC;
          cnt_d = refrac_len_q;
        end else begin
          fsm_d = ST_INTEG;
        end
      end
      ST_REFRAC: begin
        if (cnt_q <= 4'd1) fsm_d = ST_INTEG;
        else               cnt_d = cnt_q - 4'd1;
      end
      default: fsm_d = ST_INTEG;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    spike_d  = 1'b0;
    refrac_d = 1'b0;
    spike_d  = (fsm_d == ST_FIRE);
    refrac_d = (fsm_d == ST_REFRAC);
  end

  // Event FIFO: push on the edge entering FIRE; full drops unless a pop frees a slot
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    push_req_c = (fsm_q == ST_INTEG) && cross_c;
    full_c     = (count_q == CNT_W'(FIFO_DEPTH));
    pop_c      = ev_valid_q && ev_ready;
    push_ok_c  = push_req_c && (!full_c || pop_c);
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = ts_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d    = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    if (cfg_we) ovf_d = 1'b0;
    if (push_req_c && !push_ok_c) ovf_d = 1'b1;
    ev_valid_d = (count_d != '0);
    ev_ts_d    = ev_valid_d ? mem_d[rd_ptr_d] : ev_ts_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      threshold_q  <= WIDTH'(THRESH_DEFAULT);
      refrac_len_q <= 4'(REFRAC_DEFAULT);
      ts_q         <= '0;
      spike_q      <= 1'b0;
      refrac_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ev_valid_q   <= 1'b0;
      ev_ts_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      threshold_q  <= threshold_d;
      refrac_len_q <= refrac_len_d;
      ts_q         <= ts_q + TS_WIDTH'(1);
      spike_q      <= spike_d;
      refrac_q     <= refrac_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ev_valid_q   <= ev_valid_d;
      ev_ts_q      <= ev_ts_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign spike      = spike_q;
  assign refractory = refrac_q;
  assign ev_valid   = ev_valid_q;
  assign ev_ts      = ev_ts_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_lif_spike_encoder.sv
// Directed bench for lif_spike_encoder; event timestamps checked through a scoreboard queue.
module tb_lif_spike_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] state;
  logic       cfg_we;
  logic [7:0] cfg_threshold;
  logic [3:0] cfg_refrac;
  logic       spike;
  logic       refractory;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_ts;
  logic       overflow;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp;
  logic [7:0] cyc;
  logic       exp_ovf;

  always #5 clk = ~clk;

  lif_spike_encoder #(
    .WIDTH(8), .TS_WIDTH(8), .FIFO_DEPTH(4), .THRESH_DEFAULT(128), .REFRAC_DEFAULT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .state(state), .cfg_we(cfg_we),
    .cfg_threshold(cfg_threshold), .cfg_refrac(cfg_refrac), .spike(spike),
    .refractory(refractory), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_ts(ev_ts), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 8'd1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tb cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every accepted event must match the next expected timestamp
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL ev_pop: unexpected event ts=%0d, none expected", ev_ts);
      end else begin
        mon_exp = sb.pop_front();
        if (ev_ts !== mon_exp) begin
          failures++;
          $display("FAIL ev_ts: got %0d expected %0d", ev_ts, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; state = '0; cfg_we = 1'b0; cfg_threshold = '0;
    cfg_refrac = '0; ev_ready = 1'b0; cyc = '0; exp_ovf = 1'b0;
    repeat (3) tick();
    chk("rst_spike", spike, 0);
    chk("rst_refractory", refractory, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_ts", ev_ts, 0);
    chk("rst_overflow", overflow, 0);

    // Below threshold: no spikes, no events
    reset_n = 1'b1; cyc = '0;
    cfg_we = 1'b1; cfg_threshold = 8'd100; cfg_refrac = 4'd2; state = 8'd99;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("below_spike", spike, 0);
      chk("below_ev_valid", ev_valid, 0);
      tick();
    end

    // Crossing at cycle 11, refractory for 2 cycles, refire at 15
    state = 8'd100;
    sb.push_back(cyc);
    tick();
    chk("cross_spike", spike, 1);
    chk("cross_ev_valid", ev_valid, 1);
    chk("cross_ev_ts", ev_ts, 11);
    chk("cross_refr", refractory, 0);
    tick();
    chk("refr1_spike", spike, 0);
    chk("refr1", refractory, 1);
    tick();
    chk("refr2", refractory, 1);
    tick();
    chk("refr_exit", refractory, 0);
    chk("refr_exit_spike", spike, 0);
    sb.push_back(cyc);
    tick();
    chk("refire_spike", spike, 1);
    chk("refire_head", ev_ts, 11);
    state = 8'd0; ev_ready = 1'b1;
    repeat (6) tick();
    chk("drain1_ev_valid", ev_valid, 0);
    chk("drain1_sb_empty", sb.size(), 0);
    ev_ready = 1'b0;

    // Threshold 0, refrac 0: alternating spikes, fill, push+pop on full, drop, drain
    cfg_we = 1'b1; cfg_threshold = 8'd0; cfg_refrac = 4'd0; state = 8'd0;
    tick();
    cfg_we = 1'b0;
    for (int j = 0; j < 24; j++) begin
      ev_ready = (j == 8) || (j >= 12);
      chk("alt_spike", spike, 32'(j % 2));
      chk("alt_refr", refractory, 0);
      chk("alt_overflow", overflow, exp_ovf);
      if ((j % 2) == 0) begin
        if (sb.size() < 4 || ev_ready) sb.push_back(cyc);
        else exp_ovf = 1'b1;
      end
      tick();
    end

    // Config write coinciding with a crossing: old threshold 0 still fires
    cfg_we = 1'b1; cfg_threshold = 8'd255; cfg_refrac = 4'd2; ev_ready = 1'b1;
    chk("cfgx_spike", spike, 0);
    chk("cfgx_overflow_sticky", overflow, 1);
    sb.push_back(cyc);
    tick();
    cfg_we = 1'b0;
    chk("cfgx_fire", spike, 1);
    chk("cfgx_overflow_clr", overflow, 0);
    tick();
    chk("cfgx_refr", refractory, 1);
    repeat (8) tick();
    chk("drain2_ev_valid", ev_valid, 0);
    chk("drain2_sb_empty", sb.size(), 0);
    ev_ready = 1'b0;

    // Reset in REFRAC with two queued events
    cfg_we = 1'b1; cfg_threshold = 8'd10; cfg_refrac = 4'd5; state = 8'd0;
    tick();
    cfg_we = 1'b0; state = 8'd20;
    sb.push_back(cyc);
    tick();
    chk("r5_spike", spike, 1);
    repeat (5) tick();
    chk("r5_refr_last", refractory, 1);
    tick();
    chk("r5_refr_exit", refractory, 0);
    sb.push_back(cyc);
    tick();
    chk("r5_spike2", spike, 1);
    tick();
    chk("r5_refr_again", refractory, 1);
    chk("r5_queued", ev_valid, 1);
    reset_n = 1'b0;
    sb.delete();
    tick();
    chk("mid_rst_spike", spike, 0);
    chk("mid_rst_refr", refractory, 0);
    chk("mid_rst_ev_valid", ev_valid, 0);
    chk("mid_rst_ev_ts", ev_ts, 0);
    chk("mid_rst_overflow", overflow, 0);

    // Default threshold 128 boundary; timestamp restarts from 0
    reset_n = 1'b1; cyc = '0; state = 8'd127;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dflt_127_spike", spike, 0);
    end
    state = 8'd128;
    sb.push_back(cyc);
    tick();
    chk("dflt_128_spike", spike, 1);
    chk("dflt_ev_valid", ev_valid, 1);
    chk("dflt_ev_ts", ev_ts, 3);
    state = 8'd0; ev_ready = 1'b1;
    repeat (6) tick();
    chk("final_ev_valid", ev_valid, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
